// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: modulo-2^WIDTH multi-operand adder that folds one operand per
// beat into a carry-save pair and resolves it with a single carry-propagate add.
module csa_accum_sequencer #(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [3:0]       out_count,
    output logic             out_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
    logic [3:0]       cnt_q, cnt_d, count_q, count_d;
    logic             err_q, err_d;
    logic             accept;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_err   = err_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                s_d     = in_data;
                c_d     = '0;
                cnt_d   = 4'd1;
                err_d   = 1'b0;
                state_d = in_last ? RESOLVE : ACCUM;
            end
            ACCUM: if (accept) begin
                s_d   = s_q ^ c_q ^ in_data;
                c_d   = ((s_q & c_q) | (s_q & in_data) | (c_q & in_data)) << 1;
                cnt_d = cnt_q + 4'd1;
                // A packet reaching MAX_OPS without in_last is cut and flagged
                if (in_last || cnt_d == 4'(MAX_OPS)) begin
                    state_d = RESOLVE;
                    err_d   = ~in_last;
                end
            end
            RESOLVE: begin
                sum_d   = s_q + c_q;
                count_d = cnt_q;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
endmodule
